udp_rx_kernel_dispatch: RTL and testbench
=========================================

Name: udp_rx_kernel_dispatch

Overview:
- Frame-granular scheduler between the UDP offload engine RX kernel stream and NUM_CH kernel consumer channels.
- Sits in the kernel_clk domain, downstream of the RX dual-clock FIFO's kernel-side read port (valid/ready/64-bit data).
- Splits the payload word stream into fixed-length frames of frame_words words.
- Grants each frame to one eligible consumer using round-robin, then locks the grant until the frame completes.

Parameters:
NUM_CH, 4, number of consumer channels (2..8)
DATA_W, 64, payload word width
CNT_W, 16, width of frame length config and intra-frame word counter

Ports:
kernel_clk  in  1  clock
kernel_resetn  in  1  reset
enable  in  1  dispatch enable (CSR); sampled only at frame boundaries
frame_words  in  CNT_W  words per frame (CSR); latched at frame start; 0 treated as 1
ch_mask  in  NUM_CH  per-channel eligibility (1 = may be granted)
s_valid  in  1  RX FIFO not empty
s_data  in  DATA_W  RX FIFO read data
s_ready  out  1  read ack to RX FIFO
m_valid  out  NUM_CH  per-channel output valid (at most one bit set)
m_data  out  DATA_W  shared output data
m_last  out  1  qualifies final word of frame
m_ready  in  NUM_CH  per-channel consumer ready
busy  out  1  frame in progress (state STREAM or output register occupied)
cur_ch  out  3  current/last granted channel index
frame_count  out  32  completed frames, wraps at 2^32

Behaviour:
- Reset: kernel_resetn is asynchronous, active-low, and clocks on kernel_clk. On reset, all outputs go to 0, state=IDLE, rr_ptr=0, word_cnt=0, and the output register is emptied.
- A reset asserted mid-frame discards the in-flight frame. No partial-frame recovery.
- Output stage: a single output register (out_valid, out_ch, out_data, out_last).
  - m_valid[i] = out_valid && out_ch==i.
  - m_data and m_last are driven from the register.
  - Words are popped on m_ready[out_ch].
  - can_load = !out_valid || m_ready[out_ch].
- Latency: a word accepted on s_valid&&s_ready at cycle N appears on m_valid at cycle N+1. Full throughput of 1 word/cycle is sustained while the owner holds m_ready high.
- Data ordering is preserved. No word is dropped or duplicated.
- States:
  - IDLE:
    - elig = ch_mask & m_ready.
    - If enable && s_valid && elig!=0 && can_load: grant g = first set bit of elig, searching upward from rr_ptr and wrapping.
    - Assert s_ready in the same cycle and load word 0 to channel g.
    - Latch flen = max(frame_words,1).
    - If flen==1: out_last=1, frame_count+1, rr_ptr=g+1 mod NUM_CH, stay IDLE.
    - Else: word_cnt=1, owner=g, go to STREAM.
    - If no eligible channel exists: s_ready=0 and wait. No skipped-channel penalty.
  - STREAM:
    - s_ready = can_load (owner fixed). Mask, enable and m_ready of other channels are ignored.
    - On each accept, word_cnt+1.
    - When the word with word_cnt==flen-1 is accepted: out_last=1, frame_count+1, rr_ptr=owner+1 mod NUM_CH, go to IDLE.
    - Owner deasserting m_ready stalls the stream. Upstream words remain in the FIFO.
- Boundary rules:
  - enable falling mid-frame does not truncate: the frame completes, then no new grant is made.
  - ch_mask clearing the owner mid-frame has no effect until the frame ends.
  - frame_words changing mid-frame has no effect until the next frame start.
  - A single channel eligible → back-to-back grants to that channel are allowed.
  - rr_ptr wraps NUM_CH-1 → 0.
  - In IDLE with out_valid held by a stalled previous owner: the new grant waits for can_load. Output is never overwritten.
- cur_ch updates on grant. busy = (state==STREAM) || out_valid.

Test Plan:
- NUM_CH=4, frame_words=4, all mask/ready=1, 16 words 0x0..0xF continuous → ch0 gets 0-3, ch1 4-7, ch2 8-B, ch3 C-F. m_last on words 3,7,B,F. frame_count=4. Output valid 1 cycle after each accept.
- ch_mask=4'b1010, frame_words=2, 8 words → frames go ch1, ch3, ch1, ch3 (round-robin skips masked channels). frame_count=4.
- ch0 drops m_ready for 5 cycles at word 2 of a 4-word frame → s_ready=0 while stalled. Other ready channels are not granted. Frame resumes intact with no loss or duplication.
- frame_words=0 and frame_words=1, 3 words → each word is its own frame with m_last=1, rotating ch0, ch1, ch2. frame_count=3.
- enable deasserted after word 1 of a 4-word frame → words 2-3 still delivered. Afterward s_ready stays 0 despite s_valid=1. frame_count increments once.
- Reset asserted at word 2 of a frame → all outputs 0 immediately (async). After release: rr_ptr=0 and the next frame goes to ch0. frame_count=0.

Source files
------------

// File: rtl/udp_rx_kernel_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : udp_rx_kernel_dispatch
//  Description : Frame-granular round-robin scheduler between the UDP offload
//                RX kernel stream and NUM_CH kernel consumer channels. Cuts
//                the word stream into frames of frame_words words and locks
//                each frame onto a single eligible consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_rx_kernel_dispatch #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              kernel_clk,
  input  logic              kernel_resetn,
  input  logic              enable,
  input  logic [CNT_W-1:0]  frame_words,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [NUM_CH-1:0] m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic [NUM_CH-1:0] m_ready,
  output logic              busy,
  output logic [2:0]        cur_ch,
  output logic [31:0]       frame_count
);

  localparam logic [3:0] CH_COUNT = 4'(NUM_CH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        rr_ptr;
  logic [2:0]        owner;
  logic [2:0]        grant;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  flen;
  logic [CNT_W-1:0]  flen_next;

  // Single-entry output register shared by all channels
  logic              out_valid;
  logic [2:0]        out_ch;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Vectors widened to 8 so a 3-bit channel index always selects in range
  logic [7:0]        elig_ext;
  logic [7:0]        ready_ext;
  logic              out_ready;
  logic              can_load;
  logic              grant_found;
  logic              accept;

  // Channel index after ch, wrapping NUM_CH-1 back to 0
  function automatic logic [2:0] next_ch(input logic [2:0] ch);
    logic [3:0] n;
    n = {1'b0, ch} + 4'd1;
    if (n >= CH_COUNT) n = 4'd0;
    return n[2:0];
  endfunction

  assign elig_ext  = 8'(ch_mask & m_ready);
  assign ready_ext = 8'(m_ready);
  assign out_ready = ready_ext[out_ch];
  // The output register may take a new word when empty or being drained now
  assign can_load  = !out_valid || out_ready;
  // A zero-length frame request is treated as a single-word frame
  assign flen_next = (frame_words == '0) ? CNT_W'(1) : frame_words;

  // Round-robin search: first eligible channel at or above rr_ptr, wrapping
  always_comb begin
    logic [3:0] idx;
    grant_found = 1'b0;
    grant       = rr_ptr;
    idx         = 4'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= CH_COUNT) idx = idx - CH_COUNT;
      if (!grant_found && elig_ext[idx[2:0]]) begin
        grant_found = 1'b1;
        grant       = idx[2:0];
      end
    end
  end

  // Upstream read ack: grant conditions in IDLE, owner backpressure in STREAM
  always_comb begin
    s_ready = 1'b0;
    if (kernel_resetn) begin
      if (state == STREAM) s_ready = can_load;
      else                 s_ready = enable && s_valid && grant_found && can_load;
    end
  end

  assign accept = s_valid && s_ready;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_m_valid
      assign m_valid[i] = out_valid && (out_ch == 3'(i));
    end
  endgenerate

  assign m_data = out_data;
  assign m_last = out_last;
  assign busy   = (state == STREAM) || out_valid;

  // Frame state machine together with the output register it loads
  always_ff @(posedge kernel_clk or negedge kernel_resetn) begin
    if (!kernel_resetn) begin
      state       <= IDLE;
      rr_ptr      <= 3'd0;
      owner       <= 3'd0;
      word_cnt    <= '0;
      flen        <= '0;
      out_valid   <= 1'b0;
      out_ch      <= 3'd0;
      out_data    <= '0;
      out_last    <= 1'b0;
      cur_ch      <= 3'd0;
      frame_count <= 32'd0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= s_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            out_ch <= grant;
            cur_ch <= grant;
            flen   <= flen_next;
            if (flen_next == CNT_W'(1)) begin
              out_last    <= 1'b1;
              frame_count <= frame_count + 32'd1;
              rr_ptr      <= next_ch(grant);
              word_cnt    <= '0;
            end else begin
              out_last <= 1'b0;
              word_cnt <= CNT_W'(1);
              owner    <= grant;
              state    <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            out_ch <= owner;
            if (word_cnt == flen - CNT_W'(1)) begin
              out_last    <= 1'b1;
              frame_count <= frame_count + 32'd1;
              rr_ptr      <= next_ch(owner);
              word_cnt    <= '0;
              state       <= IDLE;
            end else begin
              out_last <= 1'b0;
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_kernel_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udp_rx_kernel_dispatch
//  Description : Self-checking bench for udp_rx_kernel_dispatch. A frame-level
//                reference model predicts read acks and delivered words; each
//                scenario task compares the observed streams with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_rx_kernel_dispatch;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 16;

  logic          kernel_clk = 1'b0;
  logic          kernel_resetn = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] frame_words = '0;
  logic [N-1:0]  ch_mask = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [N-1:0]  m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [N-1:0]  m_ready = '0;
  logic          busy;
  logic [2:0]    cur_ch;
  logic [31:0]   frame_count;

  udp_rx_kernel_dispatch #(.NUM_CH(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .kernel_clk    (kernel_clk),
    .kernel_resetn (kernel_resetn),
    .enable        (enable),
    .frame_words   (frame_words),
    .ch_mask       (ch_mask),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .busy          (busy),
    .cur_ch        (cur_ch),
    .frame_count   (frame_count)
  );

  always #5 kernel_clk = ~kernel_clk;

  typedef struct {
    int          cyc;
    int          ch;
    logic [63:0] data;
    bit          last;
  } rec_t;

  rec_t        obs_q[$];
  rec_t        exp_q[$];
  bit          obs_rdy[$];
  bit          exp_rdy[$];
  logic [63:0] src[$];
  bit          gap;
  int          checks;
  int          errors;
  int          cyc;

  // Reference model: frame bookkeeping plus the one-word output slot
  bit          md_in_frame;
  int          md_left;
  int          md_owner;
  int          md_rr;
  int          md_cur;
  logic [31:0] md_frames;
  bit          mo_valid;
  int          mo_ch;
  logic [63:0] mo_data;
  bit          mo_last;

  task automatic model_reset();
    md_in_frame = 0; md_left = 0; md_owner = 0; md_rr = 0; md_cur = 0;
    md_frames = 0; mo_valid = 0; mo_ch = 0; mo_data = '0; mo_last = 0;
  endtask

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete(); obs_rdy.delete(); exp_rdy.delete();
  endtask

  // One clock: present the source head, record DUT and model, advance both
  task automatic step();
    bit can_load;
    bit exp_ready;
    bit found;
    int g;
    int c;
    rec_t r;
    s_valid = (src.size() > 0) && !gap;
    s_data  = s_valid ? src[0] : '0;
    #1;
    obs_rdy.push_back(s_ready);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_ready[i]) begin
        r.cyc = cyc; r.ch = i; r.data = m_data; r.last = m_last;
        obs_q.push_back(r);
      end
    end
    can_load = !mo_valid || m_ready[mo_ch];
    found = 0; g = 0;
    if (md_in_frame) begin
      exp_ready = can_load;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (md_rr + k) % N;
        if (!found && ch_mask[c] && m_ready[c]) begin found = 1; g = c; end
      end
      exp_ready = enable && s_valid && found && can_load;
    end
    exp_rdy.push_back(exp_ready);
    if (mo_valid && m_ready[mo_ch]) begin
      r.cyc = cyc; r.ch = mo_ch; r.data = mo_data; r.last = mo_last;
      exp_q.push_back(r);
      mo_valid = 0;
    end
    if (s_valid && exp_ready) begin
      if (!md_in_frame) begin
        md_owner = g; md_cur = g; md_in_frame = 1;
        md_left = (frame_words == 0) ? 1 : int'(frame_words);
      end
      md_left--;
      mo_valid = 1; mo_ch = md_owner; mo_data = s_data; mo_last = (md_left == 0);
      if (md_left == 0) begin
        md_in_frame = 0; md_frames = md_frames + 1; md_rr = (md_owner + 1) % N;
      end
    end
    if (s_valid && s_ready) void'(src.pop_front());
    cyc++;
    @(negedge kernel_clk);
  endtask

  // Run until source and model are empty (bounded), then two idle clocks
  task automatic drain(input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      if (src.size() == 0 && !mo_valid && !md_in_frame) begin ok = 1; break; end
      step();
    end
    step();
    step();
  endtask

  task automatic test_reset();
    enable = 1; s_valid = 1; s_data = 64'hDEAD; ch_mask = '1; m_ready = '1; frame_words = 4;
    #3;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== '0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== '0 || m_last !== 1'b0) begin errors++; $display("FAIL reset_m_data: got %h/%b expected 0/0", m_data, m_last); end
    checks++; if (busy !== 1'b0 || cur_ch !== 3'd0) begin errors++; $display("FAIL reset_busy_cur: got %b/%0d expected 0/0", busy, cur_ch); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    s_valid = 0;
    @(negedge kernel_clk);
    kernel_resetn = 1;
    model_reset();
  endtask

  task automatic test_round_robin();
    bit ok;
    int base;
    logic [31:0] fc0;
    clear_logs(); base = cyc; fc0 = frame_count;
    ch_mask = '1; m_ready = '1; enable = 1; frame_words = 4; gap = 0;
    for (int i = 0; i < 16; i++) src.push_back(64'(i));
    drain(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_drain: got timeout expected completion"); end
    checks++; if (obs_q.size() != 16) begin errors++; $display("FAIL rr_count: got %0d expected 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 16; i++) begin
      checks++;
      if (obs_q[i].ch !== i / 4 || obs_q[i].data !== 64'(i) || obs_q[i].last !== (i % 4 == 3) || obs_q[i].cyc !== base + i + 1) begin
        errors++;
        $display("FAIL rr_word[%0d]: got ch%0d %h last%0d cyc%0d expected ch%0d %h last%0d cyc%0d",
                 i, obs_q[i].ch, obs_q[i].data, obs_q[i].last, obs_q[i].cyc - base, i / 4, i, i % 4 == 3, i + 1);
      end
    end
    checks++; if (frame_count - fc0 !== 32'd4) begin errors++; $display("FAIL rr_frames: got %0d expected 4", frame_count - fc0); end
  endtask

  task automatic test_stall();
    bit ok;
    int base;
    clear_logs(); base = cyc;
    ch_mask = '1; enable = 1; frame_words = 4; gap = 0;
    for (int i = 0; i < 4; i++) src.push_back(64'h100 + 64'(i));
    for (int c = 0; c < 12; c++) begin
      m_ready = (c >= 3 && c <= 7) ? 4'b1110 : 4'b1111;
      step();
    end
    m_ready = '1;
    drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_drain: got timeout expected completion"); end
    for (int c = 3; c <= 7; c++) begin
      checks++; if (obs_rdy[c] !== 1'b0) begin errors++; $display("FAIL stall_s_ready[%0d]: got %b expected 0", c, obs_rdy[c]); end
    end
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL stall_count: got %0d expected 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      checks++;
      if (obs_q[i].ch !== 0 || obs_q[i].data !== 64'h100 + 64'(i) || obs_q[i].last !== (i == 3)) begin
        errors++;
        $display("FAIL stall_word[%0d]: got ch%0d %h last%0d expected ch0 %h last%0d", i, obs_q[i].ch, obs_q[i].data, obs_q[i].last, 64'h100 + 64'(i), i == 3);
      end
    end
    checks++; if (obs_q.size() > 2 && obs_q[2].cyc !== base + 8) begin errors++; $display("FAIL stall_resume: got cyc%0d expected cyc8", obs_q[2].cyc - base); end
  endtask

  task automatic test_mask();
    bit ok;
    int exp_ch[4] = '{1, 3, 1, 3};
    logic [31:0] fc0;
    clear_logs(); fc0 = frame_count;
    ch_mask = 4'b1010; m_ready = '1; enable = 1; frame_words = 2; gap = 0;
    for (int i = 0; i < 8; i++) src.push_back($urandom());
    drain(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_drain: got timeout expected completion"); end
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL mask_count: got %0d expected 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].ch !== exp_ch[i / 2] || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== (i % 2 == 1) || obs_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL mask_word[%0d]: got ch%0d %h last%0d expected ch%0d %h last%0d", i, obs_q[i].ch, obs_q[i].data, obs_q[i].last, exp_ch[i / 2], exp_q[i].data, i % 2 == 1);
      end
    end
    checks++; if (frame_count - fc0 !== 32'd4) begin errors++; $display("FAIL mask_frames: got %0d expected 4", frame_count - fc0); end
  endtask

  task automatic test_short_frames();
    bit ok;
    int exp_ch[6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] fc0;
    clear_logs(); fc0 = frame_count;
    ch_mask = '1; m_ready = '1; enable = 1; gap = 0;
    frame_words = 0;
    for (int i = 0; i < 3; i++) src.push_back(64'h200 + 64'(i));
    drain(30, ok);
    frame_words = 1;
    for (int i = 3; i < 6; i++) src.push_back(64'h200 + 64'(i));
    drain(30, ok);
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL short_count: got %0d expected 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      checks++;
      if (obs_q[i].ch !== exp_ch[i] || obs_q[i].data !== 64'h200 + 64'(i) || obs_q[i].last !== 1'b1) begin
        errors++;
        $display("FAIL short_word[%0d]: got ch%0d %h last%0d expected ch%0d %h last1", i, obs_q[i].ch, obs_q[i].data, obs_q[i].last, exp_ch[i], 64'h200 + 64'(i));
      end
    end
    checks++; if (frame_count - fc0 !== 32'd6) begin errors++; $display("FAIL short_frames: got %0d expected 6", frame_count - fc0); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    logic [31:0] fc0;
    clear_logs(); fc0 = frame_count;
    ch_mask = '1; m_ready = '1; enable = 1; frame_words = 4; gap = 0;
    for (int i = 0; i < 8; i++) src.push_back(64'h300 + 64'(i));
    step(); step();
    enable = 0;
    for (int c = 0; c < 8; c++) step();
    for (int c = 4; c < 10; c++) begin
      checks++; if (obs_rdy[c] !== 1'b0) begin errors++; $display("FAIL endrop_s_ready[%0d]: got %b expected 0", c, obs_rdy[c]); end
    end
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL endrop_count: got %0d expected 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      checks++;
      if (obs_q[i].ch !== 2 || obs_q[i].data !== 64'h300 + 64'(i) || obs_q[i].last !== (i == 3)) begin
        errors++;
        $display("FAIL endrop_word[%0d]: got ch%0d %h last%0d expected ch2 %h last%0d", i, obs_q[i].ch, obs_q[i].data, obs_q[i].last, 64'h300 + 64'(i), i == 3);
      end
    end
    checks++; if (frame_count - fc0 !== 32'd1) begin errors++; $display("FAIL endrop_frames: got %0d expected 1", frame_count - fc0); end
    src.delete();
    enable = 1;
    drain(20, ok);
  endtask

  task automatic test_async_reset();
    bit ok;
    clear_logs();
    ch_mask = '1; m_ready = '1; enable = 1; frame_words = 4; gap = 0;
    for (int i = 0; i < 8; i++) src.push_back(64'h400 + 64'(i));
    step(); step();
    s_valid = 1; s_data = src[0];
    #2 kernel_resetn = 0;
    #1;
    checks++; if (m_valid !== '0 || s_ready !== 1'b0) begin errors++; $display("FAIL areset_valid_ready: got %b/%b expected 0/0", m_valid, s_ready); end
    checks++; if (m_data !== '0 || m_last !== 1'b0) begin errors++; $display("FAIL areset_data: got %h/%b expected 0/0", m_data, m_last); end
    checks++; if (busy !== 1'b0 || cur_ch !== 3'd0 || frame_count !== 32'd0) begin errors++; $display("FAIL areset_status: got %b/%0d/%0d expected 0/0/0", busy, cur_ch, frame_count); end
    s_valid = 0;
    src.delete();
    model_reset();
    @(negedge kernel_clk);
    @(negedge kernel_clk);
    kernel_resetn = 1;
    clear_logs();
    for (int i = 0; i < 4; i++) src.push_back(64'h500 + 64'(i));
    drain(40, ok);
    checks++; if (!ok || obs_q.size() != 4) begin errors++; $display("FAIL areset_count: got %0d expected 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      checks++;
      if (obs_q[i].ch !== 0 || obs_q[i].data !== 64'h500 + 64'(i)) begin
        errors++; $display("FAIL areset_word[%0d]: got ch%0d %h expected ch0 %h", i, obs_q[i].ch, obs_q[i].data, 64'h500 + 64'(i));
      end
    end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL areset_frames: got %0d expected 1", frame_count); end
  endtask

  task automatic test_random();
    bit ok;
    clear_logs();
    for (int i = 0; i < 400; i++) src.push_back({$urandom(), $urandom()});
    for (int n = 0; n < 6000 && src.size() > 0; n++) begin
      m_ready = 4'($urandom_range(0, 15));
      ch_mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      enable  = ($urandom_range(0, 9) != 0);
      gap     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) frame_words = 16'($urandom_range(0, 5));
      step();
    end
    m_ready = '1; ch_mask = '1; enable = 1; gap = 0;
    drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain: got timeout expected completion"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].ch !== exp_q[i].ch || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last || obs_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL rand_word[%0d]: got ch%0d %h last%0d cyc%0d expected ch%0d %h last%0d cyc%0d", i,
                 obs_q[i].ch, obs_q[i].data, obs_q[i].last, obs_q[i].cyc, exp_q[i].ch, exp_q[i].data, exp_q[i].last, exp_q[i].cyc);
      end
    end
    for (int i = 0; i < obs_rdy.size() && i < exp_rdy.size(); i++) begin
      checks++;
      if (obs_rdy[i] !== exp_rdy[i]) begin errors++; $display("FAIL rand_s_ready[%0d]: got %b expected %b", i, obs_rdy[i], exp_rdy[i]); end
    end
    checks++; if (frame_count !== md_frames) begin errors++; $display("FAIL rand_frames: got %0d expected %0d", frame_count, md_frames); end
    checks++; if (cur_ch !== 3'(md_cur)) begin errors++; $display("FAIL rand_cur_ch: got %0d expected %0d", cur_ch, md_cur); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; gap = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_stall();
    test_mask();
    test_short_frames();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
